// File: rtl/sram_arb_pkg.sv
// Shared types and SRAM idle-strobe constants for the sram_arbiter block.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } sram_state_t;

  typedef enum logic {
    GNT_IBUS = 1'b0,
    GNT_DBUS = 1'b1
  } grant_t;

  localparam logic       SRAM_CE_N_IDLE  = 1'b1;
  localparam logic       SRAM_OE_N_IDLE  = 1'b1;
  localparam logic       SRAM_WE_N_IDLE  = 1'b1;
  localparam logic [1:0] SRAM_BE_N_IDLE  = 2'b11;
  localparam logic       SRAM_DQ_OE_IDLE = 1'b0;

endpackage

// File: rtl/sram_arb_grant.sv
// Grant logic for the two bus ports; SRAM_ARB_ROUND_ROBIN_EN selects round-robin
// (with a last_grant register) instead of fixed dbus-over-ibus priority.
module sram_arb_grant
  import sram_arb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_idle,
  input  logic i_ibus_req,
  input  logic i_dbus_req,
  output logic o_gnt_ibus,
  output logic o_gnt_dbus
);

  grant_t w_gnt;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  grant_t r_last_grant;

  always_comb begin
    w_gnt = GNT_IBUS;
    if (i_ibus_req && i_dbus_req) begin
      w_gnt = (r_last_grant == GNT_IBUS) ? GNT_DBUS : GNT_IBUS;
    end else if (i_dbus_req) begin
      w_gnt = GNT_DBUS;
    end
  end

  // Only a real accept (idle with a request pending) moves the fairness pointer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_grant <= GNT_IBUS;
    end else if (i_idle && (i_ibus_req || i_dbus_req)) begin
      r_last_grant <= w_gnt;
    end
  end
`else
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = i_clk ^ i_rst;

  always_comb begin
    w_gnt = i_dbus_req ? GNT_DBUS : GNT_IBUS;
  end
`endif

  assign o_gnt_dbus = i_idle && i_dbus_req && (w_gnt == GNT_DBUS);
  assign o_gnt_ibus = i_idle && i_ibus_req && (w_gnt == GNT_IBUS);

endmodule

// File: rtl/sram_arbiter.sv
// Shares a 16-bit async SRAM between ibus (read-only) and dbus (read/write), two phases per word.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of dbus priority.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned SRAM_AW   = 18,
  parameter int unsigned PH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ibus_req,
  input  logic [SRAM_AW:0]   ibus_addr,
  output logic               ibus_ready,
  output logic               ibus_rvalid,
  output logic [31:0]        ibus_rdata,
  input  logic               dbus_req,
  input  logic               dbus_we,
  input  logic [3:0]         dbus_be,
  input  logic [SRAM_AW:0]   dbus_addr,
  input  logic [31:0]        dbus_wdata,
  output logic               dbus_ready,
  output logic               dbus_rvalid,
  output logic [31:0]        dbus_rdata,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [1:0]         sram_be_n,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in
);

  localparam int unsigned   CW       = $clog2(PH_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(PH_CYCLES - 1);

  sram_state_t        r_state, w_state_d;
  logic [CW-1:0]      r_cnt, w_cnt_d;
  logic [SRAM_AW-2:0] r_waddr, w_waddr_d;
  logic               r_we, w_we_d;
  logic [3:0]         r_be, w_be_d;
  logic [31:0]        r_wdata, w_wdata_d;
  grant_t             r_port, w_port_d;
  logic               w_gnt_ibus, w_gnt_dbus, w_last, w_hi;

  logic               r_ce_n, r_oe_n, r_we_n, r_dq_oe;
  logic               w_ce_n_d, w_oe_n_d, w_we_n_d, w_dq_oe_d;
  logic [1:0]         r_be_n, w_be_n_d;
  logic [SRAM_AW-1:0] r_addr, w_addr_d;
  logic [15:0]        r_dq_out, w_dq_out_d, r_lo;
  logic               r_ibus_rvalid, r_dbus_rvalid;
  logic [31:0]        r_ibus_rdata, r_dbus_rdata;

  logic w_unused_addr;
  assign w_unused_addr = ^{ibus_addr[1:0], dbus_addr[1:0]};

  sram_arb_grant u_grant (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_idle     (r_state == IDLE),
    .i_ibus_req (ibus_req),
    .i_dbus_req (dbus_req),
    .o_gnt_ibus (w_gnt_ibus),
    .o_gnt_dbus (w_gnt_dbus)
  );

  assign ibus_ready = w_gnt_ibus;
  assign dbus_ready = w_gnt_dbus;
  assign w_last     = (r_cnt == LAST_CNT);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_waddr_d = r_waddr;
    w_we_d    = r_we;
    w_be_d    = r_be;
    w_wdata_d = r_wdata;
    w_port_d  = r_port;
    unique case (r_state)
      IDLE: begin
        if (w_gnt_dbus || w_gnt_ibus) begin
          if (w_gnt_dbus) begin
            w_waddr_d = dbus_addr[SRAM_AW:2];
            w_we_d    = dbus_we;
            w_be_d    = dbus_be;
            w_wdata_d = dbus_wdata;
            w_port_d  = GNT_DBUS;
          end else begin
            w_waddr_d = ibus_addr[SRAM_AW:2];
            w_we_d    = 1'b0;
            w_be_d    = 4'hf;
            w_port_d  = GNT_IBUS;
          end
          w_cnt_d = '0;
          // Writes skip halves with no enabled bytes; an all-zero write never leaves IDLE.
          if (!w_we_d || (w_be_d[1:0] != 2'b00)) begin
            w_state_d = LO;
          end else if (w_be_d[3:2] != 2'b00) begin
            w_state_d = HI;
          end
        end
      end
      LO: begin
        if (w_last) begin
          w_cnt_d   = '0;
          w_state_d = (!r_we || (r_be[3:2] != 2'b00)) ? HI : IDLE;
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      HI: begin
        if (w_last) begin
          w_cnt_d   = '0;
          w_state_d = IDLE;
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Pin values for the next cycle, so every SRAM output comes straight from a flop.
  always_comb begin
    w_ce_n_d   = SRAM_CE_N_IDLE;
    w_oe_n_d   = SRAM_OE_N_IDLE;
    w_we_n_d   = SRAM_WE_N_IDLE;
    w_be_n_d   = SRAM_BE_N_IDLE;
    w_dq_oe_d  = SRAM_DQ_OE_IDLE;
    w_addr_d   = r_addr;
    w_dq_out_d = r_dq_out;
    w_hi       = (w_state_d == HI);
    if (w_state_d != IDLE) begin
      w_ce_n_d = 1'b0;
      w_addr_d = {w_waddr_d, w_hi};
      if (w_we_d) begin
        w_dq_oe_d  = 1'b1;
        w_we_n_d   = (w_cnt_d == LAST_CNT);
        w_be_n_d   = w_hi ? ~w_be_d[3:2] : ~w_be_d[1:0];
        w_dq_out_d = w_hi ? w_wdata_d[31:16] : w_wdata_d[15:0];
      end else begin
        w_oe_n_d = 1'b0;
        w_be_n_d = 2'b00;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_waddr  <= '0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_port   <= GNT_IBUS;
      r_ce_n   <= SRAM_CE_N_IDLE;
      r_oe_n   <= SRAM_OE_N_IDLE;
      r_we_n   <= SRAM_WE_N_IDLE;
      r_be_n   <= SRAM_BE_N_IDLE;
      r_dq_oe  <= SRAM_DQ_OE_IDLE;
      r_addr   <= '0;
      r_dq_out <= '0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_waddr  <= w_waddr_d;
      r_we     <= w_we_d;
      r_be     <= w_be_d;
      r_wdata  <= w_wdata_d;
      r_port   <= w_port_d;
      r_ce_n   <= w_ce_n_d;
      r_oe_n   <= w_oe_n_d;
      r_we_n   <= w_we_n_d;
      r_be_n   <= w_be_n_d;
      r_dq_oe  <= w_dq_oe_d;
      r_addr   <= w_addr_d;
      r_dq_out <= w_dq_out_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lo          <= '0;
      r_ibus_rvalid <= 1'b0;
      r_dbus_rvalid <= 1'b0;
      r_ibus_rdata  <= '0;
      r_dbus_rdata  <= '0;
    end else begin
      r_ibus_rvalid <= 1'b0;
      r_dbus_rvalid <= 1'b0;
      if ((r_state == LO) && w_last && !r_we) begin
        r_lo <= sram_dq_in;
      end
      if ((r_state == HI) && w_last && !r_we) begin
        if (r_port == GNT_DBUS) begin
          r_dbus_rvalid <= 1'b1;
          r_dbus_rdata  <= {sram_dq_in, r_lo};
        end else begin
          r_ibus_rvalid <= 1'b1;
          r_ibus_rdata  <= {sram_dq_in, r_lo};
        end
      end
    end
  end

  assign sram_ce_n   = r_ce_n;
  assign sram_oe_n   = r_oe_n;
  assign sram_we_n   = r_we_n;
  assign sram_be_n   = r_be_n;
  assign sram_addr   = r_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;
  assign ibus_rvalid = r_ibus_rvalid;
  assign ibus_rdata  = r_ibus_rdata;
  assign dbus_rvalid = r_dbus_rvalid;
  assign dbus_rdata  = r_dbus_rdata;

endmodule
